// File: rtl/change_dispenser.sv
// Change payout controller: greedy 5/2/1 coin selection against on-board stock,
// one coin at a time via a level request / acknowledge handshake.
module change_dispenser #(
  parameter int unsigned AMT_W     = 7,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned INIT_FIVE = 20,
  parameter int unsigned INIT_TWO  = 20,
  parameter int unsigned INIT_ONE  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
  input  logic             restock,
  input  logic             clear,
  input  logic             coin_ack,
  output logic             coin_five,
  output logic             coin_two,
  output logic             coin_one,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] stock_five,
  output logic [CNT_W-1:0] stock_two,
  output logic [CNT_W-1:0] stock_one
);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, GAP, DONE, FAULT} state_t;

  state_t           state_q;
  logic             five_q, two_q, one_q;
  logic             busy_q, done_q, fault_q;
  logic [AMT_W-1:0] rem_q;
  logic [CNT_W-1:0] s5_q, s2_q, s1_q;
  logic [AMT_W-1:0] issue_val;

  // Value of the coin currently on the request lines.
  assign issue_val = five_q ? AMT_W'(5) : (two_q ? AMT_W'(2) : AMT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      five_q  <= 1'b0;
      two_q   <= 1'b0;
      one_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rem_q   <= '0;
      s5_q    <= CNT_W'(INIT_FIVE);
      s2_q    <= CNT_W'(INIT_TWO);
      s1_q    <= CNT_W'(INIT_ONE);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (restock) begin
            s5_q <= CNT_W'(INIT_FIVE);
            s2_q <= CNT_W'(INIT_TWO);
            s1_q <= CNT_W'(INIT_ONE);
          end
          if (start) begin
            rem_q <= change_amount;
            if (change_amount == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= SELECT;
              busy_q  <= 1'b1;
            end
          end
        end
        SELECT: begin
          // Greedy: largest coin that fits the remainder and is in stock.
          if (rem_q >= AMT_W'(5) && s5_q != '0) begin
            five_q  <= 1'b1;
            state_q <= ISSUE;
          end else if (rem_q >= AMT_W'(2) && s2_q != '0) begin
            two_q   <= 1'b1;
            state_q <= ISSUE;
          end else if (s1_q != '0) begin
            one_q   <= 1'b1;
            state_q <= ISSUE;
          end else begin
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FAULT;
          end
        end
        ISSUE: begin
          if (coin_ack) begin
            five_q <= 1'b0;
            two_q  <= 1'b0;
            one_q  <= 1'b0;
            rem_q  <= rem_q - issue_val;
            if (five_q)     s5_q <= s5_q - 1'b1;
            else if (two_q) s2_q <= s2_q - 1'b1;
            else            s1_q <= s1_q - 1'b1;
            if (rem_q == issue_val) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP:  state_q <= SELECT;
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        FAULT: begin
          if (restock) begin
            s5_q <= CNT_W'(INIT_FIVE);
            s2_q <= CNT_W'(INIT_TWO);
            s1_q <= CNT_W'(INIT_ONE);
          end
          if (clear) begin
            fault_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coin_five  = five_q;
  assign coin_two   = two_q;
  assign coin_one   = one_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign remaining  = rem_q;
  assign stock_five = s5_q;
  assign stock_two  = s2_q;
  assign stock_one  = s1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: three instances with different
// initial stock, expected coin sequences queued at start and popped per eject.
module tb_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, restock, clear, ack;
  logic [2:0] c5, c2, c1, busy, done, fault;
  logic [6:0] amt [3];
  logic [6:0] rem [3];
  logic [7:0] s5 [3];
  logic [7:0] s2 [3];
  logic [7:0] s1 [3];

  change_dispenser #(.AMT_W(7), .CNT_W(8), .INIT_FIVE(20), .INIT_TWO(20), .INIT_ONE(20)) u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .change_amount(amt[0]), .restock(restock[0]),
    .clear(clear[0]), .coin_ack(ack[0]), .coin_five(c5[0]), .coin_two(c2[0]), .coin_one(c1[0]),
    .busy(busy[0]), .done(done[0]), .fault(fault[0]), .remaining(rem[0]),
    .stock_five(s5[0]), .stock_two(s2[0]), .stock_one(s1[0]));

  change_dispenser #(.AMT_W(7), .CNT_W(8), .INIT_FIVE(0), .INIT_TWO(20), .INIT_ONE(20)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .change_amount(amt[1]), .restock(restock[1]),
    .clear(clear[1]), .coin_ack(ack[1]), .coin_five(c5[1]), .coin_two(c2[1]), .coin_one(c1[1]),
    .busy(busy[1]), .done(done[1]), .fault(fault[1]), .remaining(rem[1]),
    .stock_five(s5[1]), .stock_two(s2[1]), .stock_one(s1[1]));

  change_dispenser #(.AMT_W(7), .CNT_W(8), .INIT_FIVE(0), .INIT_TWO(0), .INIT_ONE(2)) u2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .change_amount(amt[2]), .restock(restock[2]),
    .clear(clear[2]), .coin_ack(ack[2]), .coin_five(c5[2]), .coin_two(c2[2]), .coin_one(c1[2]),
    .busy(busy[2]), .done(done[2]), .fault(fault[2]), .remaining(rem[2]),
    .stock_five(s5[2]), .stock_two(s2[2]), .stock_one(s1[2]));

  typedef struct {
    int amount;
    int n5;
    int n2;
    int n1;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          exp_q[$];
  int          m5, m2, m1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int cv(input int i);
    return c5[i] ? 5 : (c2[i] ? 2 : (c1[i] ? 1 : 0));
  endfunction

  task automatic push_coins(input int n5, input int n2, input int n1);
    for (int k = 0; k < n5; k++) exp_q.push_back(5);
    for (int k = 0; k < n2; k++) exp_q.push_back(2);
    for (int k = 0; k < n1; k++) exp_q.push_back(1);
  endtask

  // Start a payout on instance i and follow it to done, fault or timeout.
  task automatic payout(input int i, input int a, input int ack_wait, input bit mid_start);
    int  cyc;
    int  val;
    int  rb;
    bit  first;
    bit  finished;
    amt[i]   = 7'(a);
    start[i] = 1'b1;
    tick;
    start[i] = 1'b0;
    chk("busy_after_start", busy[i], (a != 0));
    cyc = 0;
    first = 1'b1;
    finished = 1'b0;
    while (!finished) begin
      if (first && (cv(i) != 0 || done[i] || fault[i])) begin
        chk("first_latency", cyc, 1);
        first = 1'b0;
      end
      if (done[i]) begin
        chk("done_rem", rem[i], 0);
        chk("done_busy", busy[i], 0);
        tick;
        chk("done_pulse_width", done[i], 0);
        finished = 1'b1;
      end else if (fault[i]) begin
        finished = 1'b1;
      end else if (cv(i) != 0) begin
        val = cv(i);
        chk("coin_onehot", int'(c5[i]) + int'(c2[i]) + int'(c1[i]), 1);
        if (exp_q.size() == 0) chk("unexpected_coin", val, 0);
        else                   chk("coin_value", val, exp_q.pop_front());
        rb = int'(rem[i]);
        for (int k = 0; k < ack_wait; k++) begin
          if (mid_start && k == 1) begin
            amt[i]   = 7'd9;
            start[i] = 1'b1;
          end
          tick;
          start[i] = 1'b0;
          chk("coin_held", cv(i), val);
          chk("rem_hold", rem[i], rb);
        end
        ack[i] = 1'b1;
        tick;
        ack[i] = 1'b0;
        cyc++;
        chk("coin_drop", c5[i] | c2[i] | c1[i], 0);
        chk("rem_dec", rem[i], rb - val);
      end else begin
        tick;
        cyc++;
      end
      if (!finished && cyc > 300) begin
        chk("payout_timeout", cyc, 0);
        finished = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t tbl [6];
    tbl[0] = '{8, 1, 1, 1};
    tbl[1] = '{0, 0, 0, 0};
    tbl[2] = '{13, 2, 1, 1};
    tbl[3] = '{4, 0, 2, 0};
    tbl[4] = '{11, 2, 0, 1};
    tbl[5] = '{1, 0, 0, 1};

    rst = 3'b111; start = '0; restock = '0; clear = '0; ack = '0;
    for (int i = 0; i < 3; i++) amt[i] = '0;
    repeat (2) tick;
    chk("rst_coins", {c5[0], c2[0], c1[0]}, 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_fault", fault[0], 0);
    chk("rst_rem", rem[0], 0);
    chk("rst_s5", s5[0], 20);
    chk("rst_s2", s2[0], 20);
    chk("rst_s1", s1[0], 20);
    rst = '0;
    tick;

    m5 = 20; m2 = 20; m1 = 20;
    for (int v = 0; v < 6; v++) begin
      push_coins(tbl[v].n5, tbl[v].n2, tbl[v].n1);
      payout(0, tbl[v].amount, 0, 1'b0);
      m5 -= tbl[v].n5;
      m2 -= tbl[v].n2;
      m1 -= tbl[v].n1;
      chk("vec_s5", s5[0], m5);
      chk("vec_s2", s2[0], m2);
      chk("vec_s1", s1[0], m1);
      chk("vec_queue_empty", exp_q.size(), 0);
      tick;
    end

    // Slow acknowledge with a stray start pulse while the coin is pending.
    push_coins(1, 0, 0);
    payout(0, 5, 5, 1'b1);
    m5 -= 1;
    chk("slow_s5", s5[0], m5);
    chk("slow_queue_empty", exp_q.size(), 0);
    tick;
    chk("slow_idle_busy", busy[0], 0);

    ack[0] = 1'b1;
    tick;
    ack[0] = 1'b0;
    tick;
    chk("idle_ack_s1", s1[0], m1);
    chk("idle_ack_coins", {c5[0], c2[0], c1[0]}, 0);

    push_coins(0, 3, 1);
    payout(1, 7, 0, 1'b0);
    chk("nofive_s5", s5[1], 0);
    chk("nofive_s2", s2[1], 17);
    chk("nofive_s1", s1[1], 19);
    chk("nofive_queue_empty", exp_q.size(), 0);

    push_coins(0, 0, 2);
    payout(2, 3, 0, 1'b0);
    chk("short_fault", fault[2], 1);
    chk("short_rem", rem[2], 1);
    chk("short_busy", busy[2], 0);
    chk("short_s1", s1[2], 0);
    chk("short_queue_empty", exp_q.size(), 0);
    amt[2] = 7'd2;
    start[2] = 1'b1;
    tick;
    start[2] = 1'b0;
    tick;
    chk("fault_start_ignored", fault[2], 1);
    chk("fault_start_rem", rem[2], 1);
    chk("fault_start_coins", {c5[2], c2[2], c1[2]}, 0);
    restock[2] = 1'b1;
    tick;
    restock[2] = 1'b0;
    chk("fault_restock_s1", s1[2], 2);
    chk("fault_still_set", fault[2], 1);
    clear[2] = 1'b1;
    tick;
    clear[2] = 1'b0;
    chk("clear_fault", fault[2], 0);
    chk("clear_rem_kept", rem[2], 1);
    tick;
    chk("clear_idle_busy", busy[2], 0);

    amt[0] = 7'd4;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    tick;
    chk("pre_reset_two", c2[0], 1);
    rst[0] = 1'b1;
    #1;
    chk("arst_coins", {c5[0], c2[0], c1[0]}, 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_rem", rem[0], 0);
    chk("arst_s5", s5[0], 20);
    chk("arst_s2", s2[0], 20);
    chk("arst_s1", s1[0], 20);
    #2;
    rst[0] = 1'b0;
    tick;
    push_coins(0, 2, 0);
    payout(0, 4, 0, 1'b0);
    chk("post_reset_s5", s5[0], 20);
    chk("post_reset_s2", s2[0], 18);
    chk("post_reset_s1", s1[0], 20);
    chk("post_reset_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
